// File: rtl/ysyx_22050710_mem_stage_nb_pkg.sv
// Shared encodings, entry layout and sizing helpers for the non-blocking memory stage.
package ysyx_22050710_mem_stage_nb_pkg;

    localparam int unsigned MemOpWd = 3;

    typedef enum logic [MemOpWd-1:0] {
        MemLb  = 3'b000,
        MemLh  = 3'b001,
        MemLw  = 3'b010,
        MemLd  = 3'b011,
        MemLbu = 3'b100,
        MemLhu = 3'b101,
        MemLwu = 3'b110
    } mem_op_e;

    // Per-entry control bits; rd and result live in separate width-parameterised arrays.
    typedef struct packed {
        logic               gpr_wen;
        logic               ren;
        logic               wen;
        logic [MemOpWd-1:0] op;
        logic [2:0]         addr_lo;
        logic               done;
    } entry_meta_t;

    function automatic int unsigned ptr_wd(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int unsigned drop_wd(input int unsigned depth);
        return $clog2(depth + 1) + 1;
    endfunction

endpackage

// File: rtl/ysyx_22050710_mem_stage_nb_if.sv
// EX-to-MEM issue bus plus the in-order data-sram response channel.
interface ysyx_22050710_mem_stage_nb_if
    import ysyx_22050710_mem_stage_nb_pkg::*;
#(
    parameter int unsigned WORD_WD      = 64,
    parameter int unsigned GPR_ADDR_WD  = 5,
    parameter int unsigned SRAM_DATA_WD = 64
);
    logic                    es_valid;
    logic                    ms_allowin;
    logic [GPR_ADDR_WD-1:0]  es_rd;
    logic                    es_gpr_wen;
    logic                    es_mem_ren;
    logic                    es_mem_wen;
    logic [MemOpWd-1:0]      es_mem_op;
    logic [WORD_WD-1:0]      es_result;
    logic                    data_sram_data_ok;
    logic [SRAM_DATA_WD-1:0] data_sram_rdata;

    modport master (
        output es_valid, es_rd, es_gpr_wen, es_mem_ren, es_mem_wen, es_mem_op, es_result,
        output data_sram_data_ok, data_sram_rdata,
        input  ms_allowin
    );

    modport slave (
        input  es_valid, es_rd, es_gpr_wen, es_mem_ren, es_mem_wen, es_mem_op, es_result,
        input  data_sram_data_ok, data_sram_rdata,
        output ms_allowin
    );
endinterface

// File: rtl/ysyx_22050710_lsu_load_ext.sv
// Aligns raw sram read data by the byte offset and sign/zero-extends it per load type.
module ysyx_22050710_lsu_load_ext
    import ysyx_22050710_mem_stage_nb_pkg::*;
#(
    parameter int unsigned WORD_WD      = 64,
    parameter int unsigned SRAM_DATA_WD = 64
) (
    input  logic [2:0]              addr_lo_i,
    input  logic [SRAM_DATA_WD-1:0] rdata_i,
    input  logic [MemOpWd-1:0]      op_i,
    output logic [WORD_WD-1:0]      data_o
);
    logic [SRAM_DATA_WD-1:0] shifted;

    always_comb begin
        shifted = rdata_i >> {addr_lo_i, 3'b000};
        case (op_i)
            MemLb:   data_o = WORD_WD'($signed(shifted[7:0]));
            MemLh:   data_o = WORD_WD'($signed(shifted[15:0]));
            MemLw:   data_o = WORD_WD'($signed(shifted[31:0]));
            MemLd:   data_o = WORD_WD'(rdata_i);
            MemLbu:  data_o = WORD_WD'(shifted[7:0]);
            MemLhu:  data_o = WORD_WD'(shifted[15:0]);
            MemLwu:  data_o = WORD_WD'(shifted[31:0]);
            default: data_o = '0;
        endcase
    end
endmodule

// File: rtl/ysyx_22050710_mem_stage_nb.sv
// Non-blocking MEM stage: in-order queue of in-flight instructions, responses matched in request
// order, program-order retirement to WB and per-operand bypass lookups for ID.
module ysyx_22050710_mem_stage_nb
    import ysyx_22050710_mem_stage_nb_pkg::*;
#(
    parameter int unsigned WORD_WD      = 64,
    parameter int unsigned GPR_ADDR_WD  = 5,
    parameter int unsigned SRAM_DATA_WD = 64,
    parameter int unsigned DEPTH        = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    ysyx_22050710_mem_stage_nb_if.slave es_bus,
    input  logic                        i_flush,
    input  logic                        i_ws_allowin,
    output logic                        o_ms_to_ws_valid,
    output logic                        o_ws_gpr_wen,
    output logic [GPR_ADDR_WD-1:0]      o_ws_rd,
    output logic [WORD_WD-1:0]          o_ws_result,
    output logic                        o_ms_data_stall,
    input  logic [GPR_ADDR_WD-1:0]      i_ds_rs1,
    input  logic [GPR_ADDR_WD-1:0]      i_ds_rs2,
    output logic                        o_rs1_hit,
    output logic                        o_rs2_hit,
    output logic                        o_rs1_stall,
    output logic                        o_rs2_stall,
    output logic [WORD_WD-1:0]          o_rs1_data,
    output logic [WORD_WD-1:0]          o_rs2_data
);
    localparam int unsigned PtrWd  = ptr_wd(DEPTH);
    localparam int unsigned IdxWd  = PtrWd - 1;
    localparam int unsigned DropWd = drop_wd(DEPTH);

    entry_meta_t            meta_q [DEPTH];
    entry_meta_t            meta_d [DEPTH];
    logic [GPR_ADDR_WD-1:0] rd_q   [DEPTH];
    logic [GPR_ADDR_WD-1:0] rd_d   [DEPTH];
    logic [WORD_WD-1:0]     res_q  [DEPTH];
    logic [WORD_WD-1:0]     res_d  [DEPTH];
    logic [PtrWd-1:0]       head_q, head_d, tail_q, tail_d, count;
    logic [DropWd-1:0]      drop_q, drop_d, drop_total, pending;

    logic [IdxWd-1:0]       head_idx, tail_idx, resp_idx;
    logic [IdxWd-1:0]       slot_idx [DEPTH];
    logic [DEPTH-1:0]       slot_live;
    logic                   head_valid, resp_found, enq, deq, proto_err;
    logic [WORD_WD-1:0]     load_data;

    assign count             = tail_q - head_q;
    assign head_idx          = head_q[IdxWd-1:0];
    assign tail_idx          = tail_q[IdxWd-1:0];
    assign head_valid        = (count != '0);
    assign es_bus.ms_allowin = (count < PtrWd'(DEPTH));
    assign enq = es_bus.es_valid && es_bus.ms_allowin && !i_flush;
    assign deq = o_ms_to_ws_valid && i_ws_allowin;

    // Slots in program order, oldest first; the oldest undone memory entry owns the next response.
    always_comb begin
        resp_found = 1'b0;
        resp_idx   = '0;
        pending    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot_idx[k]  = head_idx + IdxWd'(k);
            slot_live[k] = (PtrWd'(k) < count);
            if (slot_live[k] && (meta_q[slot_idx[k]].ren || meta_q[slot_idx[k]].wen) &&
                !meta_q[slot_idx[k]].done) begin
                pending = pending + DropWd'(1);
                if (!resp_found) begin
                    resp_found = 1'b1;
                    resp_idx   = slot_idx[k];
                end
            end
        end
    end

    ysyx_22050710_lsu_load_ext #(
        .WORD_WD      (WORD_WD),
        .SRAM_DATA_WD (SRAM_DATA_WD)
    ) u_load_ext (
        .addr_lo_i (meta_q[resp_idx].addr_lo),
        .rdata_i   (es_bus.data_sram_rdata),
        .op_i      (meta_q[resp_idx].op),
        .data_o    (load_data)
    );

    always_comb begin
        meta_d     = meta_q;
        rd_d       = rd_q;
        res_d      = res_q;
        head_d     = head_q;
        tail_d     = tail_q;
        drop_d     = drop_q;
        drop_total = drop_q + pending;
        proto_err  = 1'b0;
        if (i_flush) begin
            // Killed requests still owe responses; a same-cycle data_ok pays the first of them.
            head_d = '0;
            tail_d = '0;
            if (es_bus.data_sram_data_ok) begin
                if (drop_total != '0) drop_total = drop_total - DropWd'(1);
                else                  proto_err  = 1'b1;
            end
            drop_d = drop_total;
        end else begin
            if (es_bus.data_sram_data_ok) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - DropWd'(1);
                end else if (resp_found) begin
                    meta_d[resp_idx].done = 1'b1;
                    if (meta_q[resp_idx].ren) res_d[resp_idx] = load_data;
                end else begin
                    proto_err = 1'b1;
                end
            end
            if (deq) head_d = head_q + PtrWd'(1);
            if (enq) begin
                rd_d[tail_idx]   = es_bus.es_rd;
                res_d[tail_idx]  = es_bus.es_result;
                meta_d[tail_idx] = '{
                    gpr_wen: es_bus.es_gpr_wen,
                    ren:     es_bus.es_mem_ren,
                    wen:     es_bus.es_mem_wen,
                    op:      es_bus.es_mem_op,
                    addr_lo: es_bus.es_result[2:0],
                    done:    !(es_bus.es_mem_ren || es_bus.es_mem_wen)
                };
                tail_d = tail_q + PtrWd'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            drop_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                meta_q[k] <= '0;
                rd_q[k]   <= '0;
                res_q[k]  <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            drop_q <= drop_d;
            meta_q <= meta_d;
            rd_q   <= rd_d;
            res_q  <= res_d;
        end
    end

    always_comb begin
        o_ms_to_ws_valid = head_valid && meta_q[head_idx].done;
        o_ms_data_stall  = head_valid && !meta_q[head_idx].done &&
                           (meta_q[head_idx].ren || meta_q[head_idx].wen);
        o_ws_gpr_wen     = o_ms_to_ws_valid && meta_q[head_idx].gpr_wen && !meta_q[head_idx].wen;
        o_ws_rd          = o_ms_to_ws_valid ? rd_q[head_idx]  : '0;
        o_ws_result      = o_ms_to_ws_valid ? res_q[head_idx] : '0;
    end

    // Later (younger) matches overwrite earlier ones, so the youngest writer wins.
    always_comb begin
        o_rs1_hit   = 1'b0;
        o_rs1_stall = 1'b0;
        o_rs1_data  = '0;
        o_rs2_hit   = 1'b0;
        o_rs2_stall = 1'b0;
        o_rs2_data  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (slot_live[k] && meta_q[slot_idx[k]].gpr_wen && !meta_q[slot_idx[k]].wen) begin
                if (i_ds_rs1 != '0 && rd_q[slot_idx[k]] == i_ds_rs1) begin
                    o_rs1_hit   = meta_q[slot_idx[k]].done;
                    o_rs1_stall = !meta_q[slot_idx[k]].done;
                    o_rs1_data  = meta_q[slot_idx[k]].done ? res_q[slot_idx[k]] : '0;
                end
                if (i_ds_rs2 != '0 && rd_q[slot_idx[k]] == i_ds_rs2) begin
                    o_rs2_hit   = meta_q[slot_idx[k]].done;
                    o_rs2_stall = !meta_q[slot_idx[k]].done;
                    o_rs2_data  = meta_q[slot_idx[k]].done ? res_q[slot_idx[k]] : '0;
                end
            end
        end
    end

`ifndef SYNTHESIS
    a_no_stray_resp: assert property (@(posedge i_clk) disable iff (!i_rst_n) !proto_err)
        else $error("data_ok with no outstanding request");
`endif

endmodule
